mem_line_responder: RTL and testbench
=====================================

// Module: mem_line_responder
// PURPOSE
// - Memory-side responder of the cache/arbiter memory interface: accepts one request at a time from the arbiter
//   (line fill or word/byte store) and answers with a full cache line plus a one-cycle response_valid pulse.
// - Backing store is a line-organised array; fixed, parameterised access latency models main memory.
// PARAMETERS
// - FILL_DATA_WIDTH   128   cache line width returned on fill_data (multiple of 32)
// - ADDRESS_WIDTH     32    request address width (byte address)
// - STORE_DATA_WIDTH  32    width of evict_data (one word)
// - DEPTH_LINES       1024  number of lines in backing array (power of two)
// - LATENCY           5     cycles from request capture to response_valid (>= 2)
// PORTS
// - clk             in   1                  clock, rising edge
// - rst             in   1                  asynchronous reset, active-high
// - req             in   1                  request valid (level), sampled only in IDLE
// - store           in   1                  1 = store, 0 = line fill
// - store_word      in   1                  1 = word store, 0 = byte store (ignored for fills)
// - address         in   ADDRESS_WIDTH      byte address of request
// - evict_data      in   STORE_DATA_WIDTH   store data; byte stores use [7:0]
// - fill_data       out  FILL_DATA_WIDTH    line at address (post-store contents for stores)
// - response_valid  out  1                  one-cycle completion pulse
// - busy            out  1                  high in BUSY and RESP
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE, counter 0, response_valid 0, busy 0, fill_data 0; array contents NOT cleared.
// - FSM IDLE -> BUSY -> RESP -> IDLE. IDLE: req=1 at edge E0 captures store/store_word/address/evict_data, goes BUSY.
// - BUSY: counter counts LATENCY-2 down to 0; at 0 next edge enters RESP. response_valid high exactly in the
//   LATENCY-th cycle after E0 (cycle following E0 is cycle 1). Inputs ignored while BUSY/RESP.
// - Line index = captured address[OFF +: log2(DEPTH_LINES)], OFF = log2(FILL_DATA_WIDTH/8); upper bits ignored (wrap).
// - Store commits on the BUSY->RESP edge: word store writes evict_data into word address[OFF-1:2] (address[1:0]
//   ignored); byte store writes evict_data[7:0] into byte address[OFF-1:0]; other bytes unchanged.
// - fill_data registered on BUSY->RESP edge; held stable until next RESP or reset. Stores return the updated line.
// - RESP -> IDLE unconditionally; requester must drop req in the cycle after response_valid, else a new
//   transaction is captured at the following edge (back-to-back allowed, no bubble beyond IDLE cycle).
// - Reset mid-transaction: captured request discarded, store not committed if BUSY->RESP edge not yet reached.
// CONFIGURATION
// - MEM_STATS_EN defined: extra outputs stat_fills, stat_stores (32 b each), reset 0, +1 on each RESP cycle of
//   that kind, saturate at 32'hFFFF_FFFF. Not defined: ports and counters absent; no other behaviour change.
// STRUCTURE
// - brisc_pkg: mem_resp_state_t enum {IDLE, BUSY, RESP}; XLEN; CACHE_LINE_WIDTH shared constant.
// - Sub-module mem_line_array: DEPTH_LINES x FILL_DATA_WIDTH storage, async read, sync byte-enable write.
// - Top: FSM, latency counter, request capture regs, byte-enable/merge generation, optional stats.
// TESTING
// - Reset: rst pulsed mid-BUSY of a store 0x40 data 0xDEADBEEF -> no response_valid; later fill 0x40 returns old line.
// - Fill latency: fill address 0x100, LATENCY=5 -> response_valid exactly in cycle 5 after capture, 1 cycle wide.
// - Word store: store_word=1, address 0x108, data 0xCAFEBABE -> fill_data[95:64]=0xCAFEBABE, other words unchanged.
// - Byte store: store_word=0, address 0x10D, data 0x5A -> fill_data[111:104]=0x5A; subsequent fill 0x100 matches.
// - Back-to-back: req held high -> second capture in IDLE cycle after RESP; requests while BUSY ignored.
// - Wrap: DEPTH_LINES=1024, store 0x4000 then fill 0x0 -> same line returned; MEM_STATS_EN counts fills=1, stores=1.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types and constants for the cache/arbiter memory side.
package brisc_pkg;
    localparam int XLEN             = 32;
    localparam int CACHE_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;
endpackage

// File: rtl/mem_line_array.sv
// Line-organised backing store: asynchronous read, synchronous byte-enable write.
module mem_line_array #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH/8-1:0]       byte_en,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are intentionally never reset; they model persistent main memory.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (we && byte_en[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: one request at a time, fixed latency, full line returned.
// Optional MEM_STATS_EN adds saturating fill/store completion counters.
module mem_line_responder
    import brisc_pkg::*;
#(
    parameter int FILL_DATA_WIDTH  = CACHE_LINE_WIDTH,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int STORE_DATA_WIDTH = XLEN,
    parameter int DEPTH_LINES      = 1024,
    parameter int LATENCY          = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        store,
    input  logic                        store_word,
    input  logic [ADDRESS_WIDTH-1:0]    address,
    input  logic [STORE_DATA_WIDTH-1:0] evict_data,
    output logic [FILL_DATA_WIDTH-1:0]  fill_data,
    output logic                        response_valid,
`ifdef MEM_STATS_EN
    output logic [31:0]                 stat_fills,
    output logic [31:0]                 stat_stores,
`endif
    output logic                        busy
);
    localparam int OFF   = $clog2(FILL_DATA_WIDTH/8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int BYTES = FILL_DATA_WIDTH/8;
    localparam int CNT_W = $clog2(LATENCY);

    mem_resp_state_t               state_reg;
    logic [CNT_W-1:0]              count_reg;
    logic                          store_reg;
    logic                          store_word_reg;
    logic [ADDRESS_WIDTH-1:0]      address_reg;
    logic [STORE_DATA_WIDTH-1:0]   evict_data_reg;

    logic [IDX_W-1:0]              line_index;
    logic [OFF-1:0]                byte_off;
    logic [FILL_DATA_WIDTH-1:0]    line_rdata;
    logic [FILL_DATA_WIDTH-1:0]    line_wdata;
    logic [FILL_DATA_WIDTH-1:0]    merged_line;
    logic [BYTES-1:0]              byte_en;
    logic                          commit;
    logic                          unused_addr_bits;

    assign line_index       = address_reg[OFF +: IDX_W];
    assign byte_off         = address_reg[OFF-1:0];
    assign commit           = (state_reg == BUSY) && (count_reg == '0);
    assign unused_addr_bits = ^address_reg;

    // Word stores replicate the word into every lane; byte stores replicate the low byte.
    // The byte enable then picks the single lane that actually changes.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign byte_en[gi] = store_reg &&
                (store_word_reg ? (32'(byte_off >> 2) == gi/4) : (32'(byte_off) == gi));
            assign line_wdata[gi*8 +: 8]  = store_word_reg ? evict_data_reg[(gi%4)*8 +: 8]
                                                           : evict_data_reg[7:0];
            assign merged_line[gi*8 +: 8] = byte_en[gi] ? line_wdata[gi*8 +: 8]
                                                        : line_rdata[gi*8 +: 8];
        end
    endgenerate

    mem_line_array #(
        .WIDTH (FILL_DATA_WIDTH),
        .DEPTH (DEPTH_LINES)
    ) u_array (
        .clk     (clk),
        .we      (commit && store_reg),
        .addr    (line_index),
        .byte_en (byte_en),
        .wdata   (line_wdata),
        .rdata   (line_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            store_reg      <= 1'b0;
            store_word_reg <= 1'b0;
            address_reg    <= '0;
            evict_data_reg <= '0;
            fill_data      <= '0;
            response_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    response_valid <= 1'b0;
                    if (req) begin
                        store_reg      <= store;
                        store_word_reg <= store_word;
                        address_reg    <= address;
                        evict_data_reg <= evict_data;
                        count_reg      <= CNT_W'(LATENCY - 2);
                        busy           <= 1'b1;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        // Merged line equals the post-store contents being written this edge.
                        fill_data      <= merged_line;
                        response_valid <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    response_valid <= 1'b0;
                    busy           <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fills  <= '0;
            stat_stores <= '0;
        end else if (state_reg == RESP) begin
            if (store_reg) begin
                if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
            end else begin
                if (stat_fills != 32'hFFFF_FFFF) stat_fills <= stat_fills + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency, stores, reset abort, back-to-back, wrap.
// Build with MEM_STATS_EN defined to also check the statistics counters.
module tb_mem_line_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req = 1'b0;
    logic         store = 1'b0;
    logic         store_word = 1'b0;
    logic [31:0]  address = '0;
    logic [31:0]  evict_data = '0;
    logic [127:0] fill_data;
    logic         response_valid;
    logic         busy;
`ifdef MEM_STATS_EN
    logic [31:0]  stat_fills;
    logic [31:0]  stat_stores;
`endif

    int errors = 0;
    int checks = 0;
    int fills_exp = 0;
    int stores_exp = 0;

    mem_line_responder dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .store          (store),
        .store_word     (store_word),
        .address        (address),
        .evict_data     (evict_data),
        .fill_data      (fill_data),
        .response_valid (response_valid),
`ifdef MEM_STATS_EN
        .stat_fills     (stat_fills),
        .stat_stores    (stat_stores),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One full transaction; reports latency (cycle number of response_valid), returned line,
    // busy in cycle 1 and response_valid in the cycle after the pulse.
    task automatic run_txn(input logic st, input logic sw, input logic [31:0] addr,
                           input logic [31:0] data, output logic [127:0] line,
                           output int lat, output logic busy_c1, output logic rv_after);
        @(negedge clk);
        req = 1'b1; store = st; store_word = sw; address = addr; evict_data = data;
        @(posedge clk); #1;
        req = 1'b0;
        busy_c1 = busy;
        lat = 1;
        while (!response_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        line = fill_data;
        @(posedge clk); #1;
        rv_after = response_valid;
        if (st) stores_exp++; else fills_exp++;
        $display("txn store=%0b word=%0b addr=%h data=%h -> line=%h lat=%0d",
                 st, sw, addr, data, line, lat);
    endtask

    localparam logic [127:0] LINE40_INIT  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE100_INIT = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    localparam logic [127:0] LINE100_WS   = 128'hD3D3D3D3_CAFEBABE_B1B1B1B1_A0A0A0A0;
    localparam logic [127:0] LINE100_BS   = 128'hD3D35AD3_CAFEBABE_B1B1B1B1_A0A0A0A0;
    localparam logic [127:0] LINE0_INIT   = 128'h00000003_00000002_00000001_0BADF00D;

    initial begin
        logic [127:0] line;
        int           lat;
        logic         b1;
        logic         rva;
        int           seen;
        logic [31:0]  w40  [4];
        logic [31:0]  w100 [4];
        logic [31:0]  w0   [4];

        w40  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        w100 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        w0   = '{32'h0BADF00D, 32'h00000001, 32'h00000002, 32'h00000003};

        rst = 1'b1;
        #12;
        check("reset_rv", {127'd0, response_valid}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_fill", fill_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 32'h40 + 32'(i*4), w40[i], line, lat, b1, rva);
        check("init_line40", line, LINE40_INIT);
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 32'h100 + 32'(i*4), w100[i], line, lat, b1, rva);
        check("init_line100", line, LINE100_INIT);
        check("store_latency", 128'(lat), 128'd5);

        run_txn(1'b0, 1'b0, 32'h100, 32'h0, line, lat, b1, rva);
        check("fill_latency", 128'(lat), 128'd5);
        check("fill_busy_c1", {127'd0, b1}, 128'd1);
        check("fill_pulse_width", {127'd0, rva}, 128'd0);
        check("fill_busy_after", {127'd0, busy}, 128'd0);
        check("fill_line100", line, LINE100_INIT);

        run_txn(1'b1, 1'b1, 32'h108, 32'hCAFEBABE, line, lat, b1, rva);
        check("word_store_line", line, LINE100_WS);
        run_txn(1'b1, 1'b0, 32'h10D, 32'h1234565A, line, lat, b1, rva);
        check("byte_store_line", line, LINE100_BS);
        run_txn(1'b0, 1'b0, 32'h100, 32'h0, line, lat, b1, rva);
        check("fill_after_stores", line, LINE100_BS);
        check("fill_hold", fill_data, LINE100_BS);

        // Reset in the middle of a store: no response, no commit.
        @(negedge clk);
        req = 1'b1; store = 1'b1; store_word = 1'b1; address = 32'h40; evict_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_fill", fill_data, 128'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (response_valid) seen++;
        end
        check("midrst_no_resp", 128'(seen), 128'd0);
        run_txn(1'b0, 1'b0, 32'h40, 32'h0, line, lat, b1, rva);
        check("midrst_old_line", line, LINE40_INIT);

        // Back-to-back: req held high; address change while BUSY is ignored.
        @(negedge clk);
        req = 1'b1; store = 1'b0; store_word = 1'b0; address = 32'h100;
        @(posedge clk); #1;
        address = 32'h40;
        lat = 1;
        while (!response_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_lat", 128'(lat), 128'd5);
        check("b2b_first_line", fill_data, LINE100_BS);
        @(posedge clk); #1;
        check("b2b_idle_busy", {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        check("b2b_second_capture", {127'd0, busy}, 128'd1);
        req = 1'b0;
        lat = 1;
        while (!response_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_lat", 128'(lat), 128'd5);
        check("b2b_second_line", fill_data, LINE40_INIT);
        fills_exp += 2;
        @(posedge clk); #1;

        // Wrap: 0x4000 aliases line 0.
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 32'h4000 + 32'(i*4), w0[i], line, lat, b1, rva);
        check("wrap_store_line", line, LINE0_INIT);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, line, lat, b1, rva);
        check("wrap_fill_line0", line, LINE0_INIT);

`ifdef MEM_STATS_EN
        check("stat_fills", {96'd0, stat_fills}, 128'(fills_exp));
        check("stat_stores", {96'd0, stat_stores}, 128'(stores_exp));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
